main_memory_responder: RTL

- Memory-side responder for the cache controller's memory request interface (MStrobe / MRW).
- Models main memory: accepts one word request per strobe, waits a fixed access latency, then performs the read or write and pulses a ready back to the controller.
- Sits between the cache controller's memory port and the cache data path. MDataOut feeds the cache refill data mux.

---
 rtl/main_memory_responder.sv | 90 +++++++++
 1 files changed

// File: rtl/main_memory_responder.sv
// main_memory_responder: fixed-latency main memory model answering cache controller requests
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   MStrobe, MRW    - request strobe (sampled in IDLE) and direction (1 = write)
//   MAddr, MDataIn  - word address and write data, latched on acceptance
//   MDataOut        - registered read data, held until the next read completes
//   MRdy, MBusy     - one-cycle completion pulse; high while a request is in flight
//   ProtErr         - sticky protocol-violation flag, cleared only by reset
module main_memory_responder #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 4,
    parameter int DEPTH   = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MStrobe,
    input  logic              MRW,
    input  logic [ADDR_W-1:0] MAddr,
    input  logic [DATA_W-1:0] MDataIn,
    output logic [DATA_W-1:0] MDataOut,
    output logic              MRdy,
    output logic              MBusy,
    output logic              ProtErr
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state_q;
    logic [7:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              rw_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              strobe_oor, req_oor, fire;

    // Zero-extend before comparing so the check stays correct when DEPTH == 2**ADDR_W.
    assign strobe_oor = 32'(MAddr) >= DEPTH;
    assign req_oor    = 32'(addr_q) >= DEPTH;
    assign fire       = (state_q == ACCESS) && (cnt_q == 8'd0);

    // Storage is never reset; a write lands only on the completing edge of an in-range request.
    always_ff @(posedge clk) begin
        if (!reset && fire && rw_q && !req_oor)
            mem[addr_q] <= data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            MRdy     <= 1'b0;
            MBusy    <= 1'b0;
            MDataOut <= '0;
            ProtErr  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (MStrobe) begin
                    addr_q  <= MAddr;
                    data_q  <= MDataIn;
                    rw_q    <= MRW;
                    cnt_q   <= 8'(LATENCY - 1);
                    MBusy   <= 1'b1;
                    state_q <= ACCESS;
                    if (strobe_oor)
                        ProtErr <= 1'b1;
                end
                ACCESS: begin
                    if (MStrobe)
                        ProtErr <= 1'b1;
                    if (cnt_q != 8'd0)
                        cnt_q <= cnt_q - 8'd1;
                    else begin
                        if (!rw_q)
                            MDataOut <= req_oor ? '0 : mem[addr_q];
                        MRdy    <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (MStrobe)
                        ProtErr <= 1'b1;
                    MRdy    <= 1'b0;
                    MBusy   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
